// File: rtl/kme_int_ctrl_gen_pkg.sv
// Shared definitions for the parametrised KME interrupt controller:
// holdoff FSM encoding, source count and default CSR offsets.
package cr_kmePKG;

    localparam int unsigned KME_INT_N_SRC = 5;

    localparam logic [10:0] KME_INT_STATUS_ADDR  = 11'h37C;
    localparam logic [10:0] KME_INT_MASK_ADDR    = 11'h380;
    localparam logic [10:0] KME_INT_FORCE_ADDR   = 11'h384;
    localparam logic [10:0] KME_INT_HOLDOFF_ADDR = 11'h388;
    localparam logic [10:0] KME_INT_FIRST_ADDR   = 11'h38C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } kme_int_fsm_e;

endpackage

// File: rtl/kme_int_ctrl_gen_holdoff_fsm.sv
// Interrupt holdoff (coalescing) FSM: asserts irq while pending, then
// keeps it low for a programmable window before looking at pending again.
module kme_int_holdoff_fsm
    import cr_kmePKG::*;
#(
    parameter int unsigned HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pending,
    input  logic [HOLD_W-1:0] i_holdoff,
    input  logic              i_bypass,
    output logic              o_irq
);

    kme_int_fsm_e      r_state;
    logic [HOLD_W-1:0] r_cnt;
    logic              r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= i_bypass;
            case (r_state)
                IDLE: begin
                    if (i_pending) begin
                        r_state <= ASSERT;
                        r_irq   <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (i_pending) begin
                        r_irq <= 1'b1;
                    end else if (i_holdoff == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= i_holdoff;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // The IDLE re-entry cycle is part of the quiet window, so leave
                    // as the count steps down to 1: irq stays low for holdoff cycles.
                    r_cnt <= r_cnt - HOLD_W'(1);
                    if (r_cnt <= HOLD_W'(2)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_irq = r_irq;

endmodule

// File: rtl/kme_int_ctrl_gen.sv
// Parametrised cr_kme interrupt controller: sticky status with level/edge
// capture, mask, W1C/W1S CSRs, first-error capture and holdoff timer.
module kme_int_ctrl_gen
    import cr_kmePKG::*;
#(
    parameter int unsigned        N_SRC         = KME_INT_N_SRC,
    parameter logic [N_SRC-1:0]   EDGE_MASK     = '0,
    parameter logic [N_SRC-1:0]   MASK_RST      = '1,
    parameter logic [N_SRC-1:0]   SUPPRESS_MASK = N_SRC'(5'b00010),
    parameter int unsigned        HOLD_W        = 16,
    parameter int unsigned        ADDR_W        = 11,
    parameter logic [ADDR_W-1:0]  STATUS_ADDR   = ADDR_W'(KME_INT_STATUS_ADDR),
    parameter logic [ADDR_W-1:0]  MASK_ADDR     = ADDR_W'(KME_INT_MASK_ADDR),
    parameter logic [ADDR_W-1:0]  FORCE_ADDR    = ADDR_W'(KME_INT_FORCE_ADDR),
    parameter logic [ADDR_W-1:0]  HOLDOFF_ADDR  = ADDR_W'(KME_INT_HOLDOFF_ADDR),
    parameter logic [ADDR_W-1:0]  FIRST_ADDR    = ADDR_W'(KME_INT_FIRST_ADDR),
    localparam int unsigned       SRC_IW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  src_in,
    input  logic              bimc_interrupt,
    input  logic              wr_stb,
    input  logic              rd_stb,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rd_ack,
    output logic [N_SRC-1:0]  int_status,
    output logic              int_out,
    output logic              suppress,
    output logic              first_valid,
    output logic [SRC_IW-1:0] first_src
);

    logic [N_SRC-1:0]  r_status, r_mask, r_prev;
    logic [HOLD_W-1:0] r_holdoff;
    logic              r_first_valid;
    logic [SRC_IW-1:0] r_first_src;

    logic [N_SRC-1:0]  w_set, w_clr, w_kept, w_status_nxt;
    logic [SRC_IW-1:0] w_low_idx;
    logic              w_wr_status, w_wr_mask, w_wr_force, w_wr_hold;
    logic [31:0]       w_rd_word;
    logic              w_pending;
    logic              w_unused_wdata;

    assign w_wr_status = wr_stb && (reg_addr == STATUS_ADDR);
    assign w_wr_mask   = wr_stb && (reg_addr == MASK_ADDR);
    assign w_wr_force  = wr_stb && (reg_addr == FORCE_ADDR);
    assign w_wr_hold   = wr_stb && (reg_addr == HOLDOFF_ADDR);

    assign w_set = (src_in & ~r_prev & EDGE_MASK)
                 | (src_in & ~EDGE_MASK)
                 | (w_wr_force ? wr_data[N_SRC-1:0] : '0);
    assign w_clr        = w_wr_status ? wr_data[N_SRC-1:0] : '0;
    assign w_kept       = r_status & ~w_clr;
    assign w_status_nxt = w_kept | w_set;

    always_comb begin
        w_low_idx = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (w_set[i-1]) w_low_idx = SRC_IW'(i - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status      <= '0;
            r_prev        <= '0;
            r_mask        <= MASK_RST;
            r_holdoff     <= '0;
            r_first_valid <= 1'b0;
            r_first_src   <= '0;
        end else begin
            r_status <= w_status_nxt;
            r_prev   <= src_in;
            if (w_wr_mask) r_mask    <= wr_data[N_SRC-1:0];
            if (w_wr_hold) r_holdoff <= wr_data[HOLD_W-1:0];
            // Capture against the post-clear state so a set racing the final clear re-arms
            if ((w_kept == '0) && (w_set != '0)) begin
                r_first_valid <= 1'b1;
                r_first_src   <= w_low_idx;
            end else if (w_status_nxt == '0) begin
                r_first_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (reg_addr == STATUS_ADDR) begin
            w_rd_word[N_SRC-1:0] = r_status;
        end else if (reg_addr == MASK_ADDR) begin
            w_rd_word[N_SRC-1:0] = r_mask;
        end else if (reg_addr == HOLDOFF_ADDR) begin
            w_rd_word[HOLD_W-1:0] = r_holdoff;
        end else if (reg_addr == FIRST_ADDR) begin
            w_rd_word[31]         = r_first_valid;
            w_rd_word[SRC_IW-1:0] = r_first_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_ack  <= 1'b0;
        end else begin
            rd_ack <= rd_stb;
            if (rd_stb) rd_data <= w_rd_word;
        end
    end

    assign w_pending      = |(r_status & r_mask);
    assign w_unused_wdata = ^wr_data;

    kme_int_holdoff_fsm #(
        .HOLD_W (HOLD_W)
    ) u_holdoff (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pending (w_pending),
        .i_holdoff (r_holdoff),
        .i_bypass  (bimc_interrupt),
        .o_irq     (int_out)
    );

    assign int_status  = r_status;
    assign suppress    = |(r_status & SUPPRESS_MASK);
    assign first_valid = r_first_valid;
    assign first_src   = r_first_src;

endmodule

// File: tb/tb_kme_int_ctrl_gen.sv
// Self-checking bench for kme_int_ctrl_gen (N_SRC=5, source 3 edge-detected).
module tb_kme_int_ctrl_gen;

    localparam logic [10:0] A_STATUS = 11'h37C;
    localparam logic [10:0] A_MASK   = 11'h380;
    localparam logic [10:0] A_FORCE  = 11'h384;
    localparam logic [10:0] A_HOLD   = 11'h388;
    localparam logic [10:0] A_FIRST  = 11'h38C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  src_in;
    logic        bimc_interrupt;
    logic        wr_stb, rd_stb;
    logic [10:0] reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic [4:0]  int_status;
    logic        int_out, suppress, first_valid;
    logic [2:0]  first_src;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      n_chk  = 0;
    int      n_fail = 0;

    kme_int_ctrl_gen #(
        .N_SRC     (5),
        .EDGE_MASK (5'b01000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_in         (src_in),
        .bimc_interrupt (bimc_interrupt),
        .wr_stb         (wr_stb),
        .rd_stb         (rd_stb),
        .reg_addr       (reg_addr),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .rd_ack         (rd_ack),
        .int_status     (int_status),
        .int_out        (int_out),
        .suppress       (suppress),
        .first_valid    (first_valid),
        .first_src      (first_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [10:0] addr, input logic [31:0] data);
        wr_stb   = 1'b1;
        reg_addr = addr;
        wr_data  = data;
        tick();
        wr_stb   = 1'b0;
    endtask

    task automatic csr_rd(input logic [10:0] addr, input logic [31:0] exp, input string tag);
        rd_q.push_back('{tag: tag, data: exp});
        rd_stb   = 1'b1;
        reg_addr = addr;
        tick();
        rd_stb   = 1'b0;
    endtask

    always @(negedge clk) begin : rd_monitor
        rd_exp_t e;
        if (rd_ack === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("rd_ack_unexpected", 32'(rd_ack), 32'd0);
            end else begin
                e = rd_q.pop_front();
                chk(e.tag, rd_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; src_in = '0; bimc_interrupt = 1'b0;
        wr_stb = 1'b0; rd_stb = 1'b0; reg_addr = '0; wr_data = '0;
        tick(); tick();
        chk("rst_status", 32'(int_status), 32'd0);
        chk("rst_int_out", 32'(int_out), 32'd0);
        chk("rst_first_valid", 32'(first_valid), 32'd0);
        chk("rst_first_src", 32'(first_src), 32'd0);
        chk("rst_suppress", 32'(suppress), 32'd0);
        chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        tick();
        csr_rd(A_MASK,   32'h1F, "rd_mask_rst");
        csr_rd(A_HOLD,   32'h0,  "rd_hold_rst");
        csr_rd(A_FIRST,  32'h0,  "rd_first_rst");
        csr_rd(A_FORCE,  32'h0,  "rd_force_wo");
        csr_rd(11'h000,  32'h0,  "rd_unmapped");

        // Level source 2, one-cycle pulse
        src_in = 5'b00100; tick(); src_in = '0;
        chk("lvl_status", 32'(int_status), 32'h04);
        chk("lvl_int_t1", 32'(int_out), 32'd0);
        tick();
        chk("lvl_int_t2", 32'(int_out), 32'd1);
        chk("lvl_first_src", 32'(first_src), 32'd2);
        chk("lvl_first_valid", 32'(first_valid), 32'd1);
        csr_rd(A_FIRST,  32'h8000_0002, "rd_first_src2");
        csr_rd(A_STATUS, 32'h4, "rd_status_src2");

        // Set beats a same-cycle W1C, then a clean clear
        src_in = 5'b00100; csr_wr(A_STATUS, 32'h4); src_in = '0;
        chk("setwins_status", 32'(int_status), 32'h04);
        csr_wr(A_STATUS, 32'h4);
        chk("clr_status", 32'(int_status), 32'h0);
        chk("clr_first_valid", 32'(first_valid), 32'd0);
        tick();
        chk("clr_int_out", 32'(int_out), 32'd0);

        // Edge-mode source 3 held high for 20 cycles, W1C on cycle 5
        for (int c = 1; c <= 20; c++) begin
            src_in = 5'b01000;
            if (c == 5) begin
                wr_stb = 1'b1; reg_addr = A_STATUS; wr_data = 32'h8;
            end else begin
                wr_stb = 1'b0;
            end
            tick();
            chk("edge_hold", 32'(int_status[3]), (c < 5) ? 32'd1 : 32'd0);
            if (c == 1) chk("edge_first_src", 32'(first_src), 32'd3);
        end
        wr_stb = 1'b0; src_in = '0; tick();
        src_in = 5'b01000; tick(); src_in = '0;
        chk("edge_rearm", 32'(int_status[3]), 32'd1);
        csr_wr(A_STATUS, 32'h8);
        tick();
        chk("edge_clr_int", 32'(int_out), 32'd0);
        chk("edge_clr_status", 32'(int_status), 32'd0);

        // Mask, force, unmask, bimc bypass
        csr_wr(A_MASK, 32'h0);
        csr_wr(A_FORCE, 32'h2);
        chk("force_status", 32'(int_status), 32'h02);
        chk("force_suppress", 32'(suppress), 32'd1);
        tick();
        chk("force_masked_int", 32'(int_out), 32'd0);
        csr_wr(A_MASK, 32'h2);
        chk("unmask_int_t0", 32'(int_out), 32'd0);
        tick();
        chk("unmask_int_t1", 32'(int_out), 32'd1);
        csr_wr(A_MASK, 32'h0);
        tick();
        chk("remask_int", 32'(int_out), 32'd0);
        bimc_interrupt = 1'b1; tick(); bimc_interrupt = 1'b0;
        chk("bimc_int", 32'(int_out), 32'd1);
        tick();
        chk("bimc_int_drop", 32'(int_out), 32'd0);
        rd_q.push_back('{tag: "rdwr_old_mask", data: 32'h0});
        rd_stb = 1'b1; wr_stb = 1'b1; reg_addr = A_MASK; wr_data = 32'hFFFF_FFE1;
        tick();
        rd_stb = 1'b0; wr_stb = 1'b0;
        csr_rd(A_MASK, 32'h1, "rd_mask_upper");
        csr_wr(A_STATUS, 32'h2);
        chk("force_clr_suppress", 32'(suppress), 32'd0);

        // Holdoff window of 10; source 0 re-fires inside it; HOLDOFF rewritten mid-hold
        csr_wr(A_HOLD, 32'd10);
        csr_rd(A_HOLD, 32'd10, "rd_hold10");
        src_in = 5'b00001; tick(); src_in = '0;
        tick();
        chk("hold_int_on", 32'(int_out), 32'd1);
        csr_wr(A_STATUS, 32'h1);
        chk("hold_exit_int", 32'(int_out), 32'd1);
        tick();
        chk("hold_win_0", 32'(int_out), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            src_in = (k == 1) ? 5'b00001 : 5'b00000;
            if (k == 2) begin
                wr_stb = 1'b1; reg_addr = A_HOLD; wr_data = 32'd8;
            end else begin
                wr_stb = 1'b0;
            end
            tick();
            chk("hold_win", 32'(int_out), (k == 10) ? 32'd1 : 32'd0);
        end
        src_in = '0; wr_stb = 1'b0;
        csr_rd(A_HOLD, 32'd8, "rd_hold8");

        // Reset while in HOLD with the count at 7
        csr_wr(A_STATUS, 32'h1);
        tick();
        csr_wr(A_FORCE, 32'h2);
        chk("pre_rst_status", 32'(int_status), 32'h02);
        chk("pre_rst_first_src", 32'(first_src), 32'd1);
        chk("pre_rst_int", 32'(int_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_status", 32'(int_status), 32'd0);
        chk("arst_suppress", 32'(suppress), 32'd0);
        chk("arst_first_valid", 32'(first_valid), 32'd0);
        chk("arst_first_src", 32'(first_src), 32'd0);
        chk("arst_int_out", 32'(int_out), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_rd_ack", 32'(rd_ack), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_int", 32'(int_out), 32'd0);
        csr_rd(A_MASK,  32'h1F, "rd_mask_after_rst");
        csr_rd(A_FIRST, 32'h0,  "rd_first_after_rst");
        csr_rd(A_HOLD,  32'h0,  "rd_hold_after_rst");

        for (int i = 0; i < 20 && rd_q.size() != 0; i++) tick();
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
